fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl.sv | 81 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: pops a fixed-latency FIFO into a 2-entry in-order
// output buffer and presents it on a valid/ready downstream port.
module fifo_rd_ctrl #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data_out,
  output logic              fifo_rd_enb,
  input  logic              ready_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  rd_count
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]        occ_q, occ_d;
  logic              infl_q, infl_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              xfer;
  logic [2:0]        occ_nxt;

  always_comb begin
    valid_out   = (occ_q != S_EMPTY);
    xfer        = valid_out & ready_in;
    occ_nxt     = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, xfer};
    // Only pop when the word it produces is guaranteed a buffer slot.
    fifo_rd_enb = rst & en & ~fifo_empty & (occ_nxt < 3'd2);
    occ_d       = occ_nxt[1:0];
    infl_d      = fifo_rd_enb;
    cnt_d       = cnt_q + CNT_W'(xfer);
    head_d      = head_q;
    tail_d      = tail_q;
    // tail is kept at 0 whenever it does not hold a word, so shifting it
    // into head also empties cleanly.
    case (occ_q)
      S_EMPTY: begin
        if (infl_q) head_d = fifo_data_out;
      end
      S_ONE: begin
        if (infl_q && xfer) head_d = fifo_data_out;
        else if (infl_q)    tail_d = fifo_data_out;
        else if (xfer)      head_d = '0;
      end
      S_TWO: begin
        if (xfer) begin
          head_d = tail_q;
          tail_d = infl_q ? fifo_data_out : '0;
        end
      end
      default: ;
    endcase
    data_out = head_q;
    rd_count = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q  <= S_EMPTY;
      infl_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      infl_q <= infl_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: emulated FIFO, queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fifo_rd_ctrl;
  localparam int DW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0, en = 1'b0, ready_in = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_rd_enb, valid_out, rd_enb3, valid3;
  logic [DW-1:0] data_out, data3;
  logic [7:0]    rd_count;
  logic [2:0]    rd_count3;

  fifo_rd_ctrl #(.DATA_W(DW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_rd_enb(fifo_rd_enb),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
    .rd_count(rd_count));

  fifo_rd_ctrl #(.DATA_W(DW), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_rd_enb(rd_enb3),
    .ready_in(ready_in), .valid_out(valid3), .data_out(data3),
    .rd_count(rd_count3));

  // FIFO emulation: data appears the cycle after the pop, garbage otherwise
  logic [DW-1:0] mem [0:255];
  int wr_ptr = 0, rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_enb && !fifo_empty) begin
      fifo_data_out <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end else begin
      fifo_data_out <= 10'h3a5;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue of popped words
  int  m_buf[$];
  bit  m_infl = 1'b0;
  int  m_word = 0;
  int  m_cnt = 0;
  bit  m_fresh = 1'b1;
  int  cyc = 0;
  int  pop_cyc[$], xfer_cyc[$], xfer_word[$];
  bit  exp_v, exp_x, exp_rd;

  always @(negedge clk) begin
    cyc++;
    exp_v  = (m_buf.size() > 0);
    exp_x  = exp_v && ready_in;
    exp_rd = rst && en && !fifo_empty &&
             ((m_buf.size() + int'(m_infl) - int'(exp_x)) < 2);
    chk("valid_out", int'(valid_out), int'(exp_v));
    chk("fifo_rd_enb", int'(fifo_rd_enb), int'(exp_rd));
    chk("rd_count", int'(rd_count), m_cnt % 256);
    chk("rd_count3", int'(rd_count3), m_cnt % 8);
    chk("valid3", int'(valid3), int'(exp_v));
    if (exp_v) begin
      chk("data_out", int'(data_out), m_buf[0]);
      chk("data3", int'(data3), m_buf[0]);
    end else if (m_fresh) begin
      chk("data_out_zero", int'(data_out), 0);
    end
    if (!rst) begin
      m_buf.delete();
      m_infl  = 1'b0;
      m_cnt   = 0;
      m_fresh = 1'b1;
    end else begin
      if (exp_x) begin
        xfer_word.push_back(m_buf.pop_front());
        xfer_cyc.push_back(cyc);
        m_cnt++;
      end
      if (m_infl) begin
        m_buf.push_back(m_word);
        m_fresh = 1'b0;
      end
      m_infl = exp_rd;
      if (exp_rd) begin
        m_word = int'(mem[rd_ptr]);
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int v);
    mem[wr_ptr] = DW'(v);
    wr_ptr++;
  endtask

  int p0, x0;
  int w6[6] = '{25, 45, 65, 85, 105, 125};

  initial begin
    // preload during reset, then stream at full rate
    rst = 1'b0; en = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 6; i++) push(w6[i]);
    step(3);
    @(negedge clk);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_rdenb", int'(fifo_rd_enb), 0);
    p0 = pop_cyc.size(); x0 = xfer_word.size();
    @(posedge clk); #1; rst = 1'b1;
    step(10);
    chk("s1_pops", pop_cyc.size() - p0, 6);
    chk("s1_pop_span", pop_cyc[p0+5] - pop_cyc[p0], 5);
    chk("s1_latency", xfer_cyc[x0] - pop_cyc[p0], 2);
    chk("s1_xfer_span", xfer_cyc[x0+5] - xfer_cyc[x0], 5);
    for (int i = 0; i < 6; i++) chk($sformatf("s1_word%0d", i), xfer_word[x0+i], w6[i]);
    chk("s1_rd_count", int'(rd_count), 6);

    // backpressure for 5 cycles
    rst = 1'b0; step(2);
    for (int i = 0; i < 6; i++) push(w6[i]);
    ready_in = 1'b0;
    p0 = pop_cyc.size(); x0 = xfer_word.size();
    rst = 1'b1;
    step(5);
    @(negedge clk);
    chk("s2_pops", pop_cyc.size() - p0, 2);
    chk("s2_valid", int'(valid_out), 1);
    chk("s2_hold", int'(data_out), 25);
    @(posedge clk); #1; ready_in = 1'b1;
    step(10);
    chk("s2_xfers", xfer_word.size() - x0, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("s2_word%0d", i), xfer_word[x0+i], w6[i]);

    // empty FIFO, then a single word
    step(2);
    @(negedge clk);
    chk("s3_rdenb", int'(fifo_rd_enb), 0);
    chk("s3_valid", int'(valid_out), 0);
    @(posedge clk); #1;
    p0 = pop_cyc.size(); x0 = xfer_word.size();
    push(145);
    step(5);
    chk("s3_pops", pop_cyc.size() - p0, 1);
    chk("s3_xfers", xfer_word.size() - x0, 1);
    chk("s3_word", xfer_word[x0], 145);

    // en dropped right after a pop
    en = 1'b0;
    push(200); push(201); push(202);
    p0 = pop_cyc.size(); x0 = xfer_word.size();
    step(2);
    en = 1'b1; step(1); en = 1'b0;
    step(6);
    chk("s4_pops_en0", pop_cyc.size() - p0, 1);
    chk("s4_word0", xfer_word[x0], 200);
    en = 1'b1; step(6);
    chk("s4_pops", pop_cyc.size() - p0, 3);
    chk("s4_word1", xfer_word[x0+1], 201);
    chk("s4_word2", xfer_word[x0+2], 202);

    // reset with a full buffer discards it; the FIFO is not re-read
    ready_in = 1'b0;
    for (int i = 0; i < 6; i++) push(300 + i);
    step(3);
    rst = 1'b0; step(1);
    @(negedge clk);
    chk("s5_valid", int'(valid_out), 0);
    chk("s5_count", int'(rd_count), 0);
    chk("s5_rdenb", int'(fifo_rd_enb), 0);
    @(posedge clk); #1;
    p0 = pop_cyc.size(); x0 = xfer_word.size();
    step(2);
    chk("s5_nopop", pop_cyc.size() - p0, 0);
    rst = 1'b1; ready_in = 1'b1;
    step(8);
    chk("s5_xfers", xfer_word.size() - x0, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("s5_word%0d", i), xfer_word[x0+i], 302 + i);

    // counter wrap on the 3-bit instance
    rst = 1'b0; step(2);
    for (int i = 0; i < 9; i++) push(400 + i);
    rst = 1'b1;
    step(14);
    chk("s6_count3", int'(rd_count3), 1);
    chk("s6_count8", int'(rd_count), 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
